// File: rtl/ws2812_chain_drv.sv
// WS2812 chain driver: streams LED_NUM pixels GRB/MSB-first, then holds the line low to latch; start->first rise 3 cycles.
// No backpressure: start is only taken in IDLE and ignored while busy. WS2812_BRIGHT_EN adds the bright scaling port.
module ws2812_chain_drv #(
    parameter int CLK_FRE  = 50_000_000,
    parameter int LED_NUM  = 8,
    parameter int T0H_NS   = 400,
    parameter int T1H_NS   = 850,
    parameter int TBIT_NS  = 1250,
    parameter int RESET_US = 80,
    localparam int ADDR_W  = (LED_NUM > 1) ? $clog2(LED_NUM) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pix_rd,
    output logic [ADDR_W-1:0] pix_addr,
    input  logic [23:0]       pix_data,
`ifdef WS2812_BRIGHT_EN
    input  logic [7:0]        bright,
`endif
    output logic              dat_o
);

    localparam int CPM   = CLK_FRE / 1_000_000;
    localparam int C0H   = CPM * T0H_NS / 1000;
    localparam int C1H   = CPM * T1H_NS / 1000;
    localparam int CBIT  = CPM * TBIT_NS / 1000;
    localparam int CRST  = CPM * RESET_US;
    localparam int CMAX  = (CRST > CBIT) ? CRST : CBIT;
    localparam int CNT_W = $clog2(CMAX + 1);

    localparam logic [CNT_W-1:0]  C0H_M1   = CNT_W'(C0H - 1);
    localparam logic [CNT_W-1:0]  C1H_M1   = CNT_W'(C1H - 1);
    localparam logic [CNT_W-1:0]  CBIT_M1  = CNT_W'(CBIT - 1);
    localparam logic [CNT_W-1:0]  CRST_M1  = CNT_W'(CRST - 1);
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(LED_NUM - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_CAPT, S_HIGH, S_LOW, S_LATCH
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [4:0]          bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [23:0]         shift_q, shift_d;
    logic [23:0]         next_buf_q, next_buf_d;
    logic                pend_q, pend_d;
    logic                last_pix;
    logic [CNT_W-1:0]    high_m1;

    function automatic logic [7:0] scale(input logic [7:0] c);
`ifdef WS2812_BRIGHT_EN
        logic [15:0] prod;
        prod = 16'(c) * (16'(bright) + 16'd1);
        return prod[15:8];
`else
        return c;
`endif
    endfunction

    // Store holds {R,G,B}; the strip expects G first.
    function automatic logic [23:0] to_grb(input logic [23:0] px);
        return {scale(px[15:8]), scale(px[23:16]), scale(px[7:0])};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            pix_cnt_q  <= '0;
            addr_q     <= '0;
            shift_q    <= '0;
            next_buf_q <= '0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            pix_cnt_q  <= pix_cnt_d;
            addr_q     <= addr_d;
            shift_q    <= shift_d;
            next_buf_q <= next_buf_d;
            pend_q     <= pend_d;
        end
    end

    assign last_pix = (pix_cnt_q == LAST_PIX);
    assign high_m1  = shift_q[23] ? C1H_M1 : C0H_M1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        pix_cnt_d  = pix_cnt_q;
        addr_d     = addr_q;
        shift_d    = shift_q;
        next_buf_d = next_buf_q;
        pend_d     = 1'b0;
        busy       = (state_q != S_IDLE);
        done       = 1'b0;
        pix_rd     = 1'b0;
        pix_addr   = addr_q;
        dat_o      = 1'b0;

        if (pend_q) begin
            next_buf_d = to_grb(pix_data);
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_FETCH;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    pix_cnt_d = '0;
                end
            end
            S_FETCH: begin
                pix_rd   = 1'b1;
                pix_addr = '0;
                addr_d   = '0;
                state_d  = S_CAPT;
            end
            S_CAPT: begin
                shift_d = to_grb(pix_data);
                cnt_d   = '0;
                state_d = S_HIGH;
            end
            S_HIGH: begin
                dat_o = 1'b1;
                // Fetch pixel n+1 while pixel n is on the wire so the next pixel follows with no gap.
                if (bit_cnt_q == 5'd0 && cnt_q == '0 && !last_pix) begin
                    pix_rd   = 1'b1;
                    pix_addr = pix_cnt_q + ADDR_W'(1);
                    addr_d   = pix_cnt_q + ADDR_W'(1);
                    pend_d   = 1'b1;
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == high_m1) begin
                    state_d = S_LOW;
                end
            end
            S_LOW: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CBIT_M1) begin
                    cnt_d = '0;
                    if (bit_cnt_q == 5'd23) begin
                        if (!last_pix) begin
                            shift_d   = next_buf_q;
                            pix_cnt_d = pix_cnt_q + ADDR_W'(1);
                            bit_cnt_d = '0;
                            state_d   = S_HIGH;
                        end else begin
                            state_d = S_LATCH;
                        end
                    end else begin
                        shift_d   = {shift_q[22:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        state_d   = S_HIGH;
                    end
                end
            end
            S_LATCH: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CRST_M1) begin
                    done    = 1'b1;
                    busy    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ws2812_chain_drv.sv
// Bench for ws2812_chain_drv at 50 MHz: a 2-pixel chain and a 1-pixel chain sharing one clock.
// Frames are decoded from dat_o and checked against hand-computed GRB streams and timing.
module tb_ws2812_chain_drv;

    localparam int C0H    = 20;
    localparam int C1H    = 42;
    localparam int CBIT   = 62;
    localparam int CRST   = 4000;
    localparam int BUDGET = 8000;

    typedef struct {
        logic [23:0] px0;
        logic [23:0] px1;
        logic [47:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st0 = 1'b0;
    logic        st1 = 1'b0;
    logic        busy0, done0, rd0, dat0;
    logic [0:0]  addr0;
    logic [23:0] pd0;
    logic        busy1, done1, rd1, dat1;
    logic [0:0]  addr1;
    logic [23:0] pd1;
    logic [23:0] mem0 [2];
    logic [23:0] mem1;
    int          n_tests = 0;
    int          n_fail  = 0;
`ifdef WS2812_BRIGHT_EN
    logic [7:0]  bright_v = 8'd255;
`endif

    always #5 clk = ~clk;

    ws2812_chain_drv #(.LED_NUM(2)) u_dut0 (
        .clk(clk), .rst(rst), .start(st0), .busy(busy0), .done(done0),
        .pix_rd(rd0), .pix_addr(addr0), .pix_data(pd0),
`ifdef WS2812_BRIGHT_EN
        .bright(bright_v),
`endif
        .dat_o(dat0)
    );

    ws2812_chain_drv #(.LED_NUM(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(st1), .busy(busy1), .done(done1),
        .pix_rd(rd1), .pix_addr(addr1), .pix_data(pd1),
`ifdef WS2812_BRIGHT_EN
        .bright(bright_v),
`endif
        .dat_o(dat1)
    );

    // Pixel stores with one cycle of read latency.
    always_ff @(posedge clk) begin
        if (rd0) pd0 <= mem0[addr0];
        if (rd1) pd1 <= mem1;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts a frame in the next cycle (sel picks the chain) and checks it through done.
    task automatic run_frame(input bit sel, input logic [47:0] exp, input int nbits,
                             input bit hold, input string tag);
        int c, rise_c, last_rise, nrise, done_c, nrd, bad_addr, bad_hi, bad_per, busy_drop, hl, eh, k;
        logic [47:0] got;
        logic pd, d, b, dn, rd, busy_at_done;
        int a;
        rise_c = -1; last_rise = 0; nrise = 0; done_c = -1; nrd = 0;
        bad_addr = 0; bad_hi = 0; bad_per = 0; busy_drop = 0;
        got = '0; pd = 1'b0; busy_at_done = 1'b1;
        step();
        if (sel) st1 = 1'b1; else st0 = 1'b1;
        for (c = 1; c <= BUDGET; c++) begin
            step();
            if (!hold) begin st0 = 1'b0; st1 = 1'b0; end
            d  = sel ? dat1  : dat0;
            b  = sel ? busy1 : busy0;
            dn = sel ? done1 : done0;
            rd = sel ? rd1   : rd0;
            a  = sel ? int'(addr1) : int'(addr0);
            if (d && !pd) begin
                if (nrise == 0) rise_c = c;
                else if (c - last_rise != CBIT) bad_per++;
                last_rise = c;
                nrise++;
            end
            if (!d && pd) begin
                hl  = c - last_rise;
                got = {got[46:0], (hl > 31)};
                k   = nrise - 1;
                eh  = (k < nbits) ? (exp[nbits-1-k] ? C1H : C0H) : -1;
                if (hl != eh) bad_hi++;
            end
            if (rd) begin
                if (a != nrd) bad_addr++;
                nrd++;
            end
            if (dn) begin
                done_c = c;
                busy_at_done = b;
                break;
            end
            if (!b) busy_drop++;
            pd = d;
        end
        st0 = 1'b0;
        st1 = 1'b0;
        chk({tag, " rise_cycle"}, rise_c, 3);
        chk({tag, " bit_count"}, nrise, nbits);
        chk({tag, " stream"}, got, exp);
        chk({tag, " high_len_errs"}, bad_hi, 0);
        chk({tag, " period_errs"}, bad_per, 0);
        chk({tag, " rd_pulses"}, nrd, nbits / 24);
        chk({tag, " rd_addr_errs"}, bad_addr, 0);
        chk({tag, " busy_gaps"}, busy_drop, 0);
        chk({tag, " busy_at_done"}, busy_at_done, 0);
        // done lands on the last cycle of a span of nbits*CBIT + CRST cycles starting at the first rise.
        chk({tag, " done_cycle"}, done_c, rise_c + nbits * CBIT + CRST - 1);
        chk({tag, " latch_len"}, done_c - (last_rise + CBIT) + 1, CRST);
    endtask

    initial begin
        vec_t vecs [3];
        int   nr;
        logic pdat;
        vecs[0] = '{px0: 24'hFF0000, px1: 24'h000001, exp: 48'h00FF00_000001};
        vecs[1] = '{px0: 24'h123456, px1: 24'hABCDEF, exp: 48'h341256_CDABEF};
        vecs[2] = '{px0: 24'hA5C33C, px1: 24'h800001, exp: 48'hC3A53C_008001};

        repeat (3) step();
        chk("reset dat_o", dat0, 0);
        chk("reset busy", busy0, 0);
        chk("reset done", done0, 0);
        chk("reset pix_rd", rd0, 0);
        chk("reset pix_addr", addr0, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            mem0[0] = vecs[i].px0;
            mem0[1] = vecs[i].px1;
            run_frame(1'b0, vecs[i].exp, 48, 1'b0, $sformatf("vec%0d", i));
        end

        // start held high across a whole frame must not retrigger it
        mem0[0] = vecs[1].px0;
        mem0[1] = vecs[1].px1;
        run_frame(1'b0, vecs[1].exp, 48, 1'b1, "hold");
        step();
        chk("hold idle_after_done", busy0, 0);

        // reset in the middle of bit 10 of pixel 1 (35th bit on the wire)
        mem0[0] = vecs[0].px0;
        mem0[1] = vecs[0].px1;
        step();
        st0 = 1'b1;
        step();
        st0 = 1'b0;
        nr = 0;
        pdat = 1'b0;
        for (int c = 0; c < BUDGET && nr < 35; c++) begin
            step();
            if (dat0 && !pdat) nr++;
            pdat = dat0;
        end
        chk("midrst reached_bit", nr, 35);
        chk("midrst busy_before", busy0, 1);
        rst = 1'b1;
        step();
        chk("midrst dat_o", dat0, 0);
        chk("midrst busy", busy0, 0);
        chk("midrst pix_rd", rd0, 0);
        chk("midrst done", done0, 0);
        chk("midrst pix_addr", addr0, 0);
        rst = 1'b0;
        run_frame(1'b0, vecs[0].exp, 48, 1'b0, "after_rst");

        mem1 = 24'h5A3CC3;
        run_frame(1'b1, 48'h3C5AC3, 24, 1'b0, "one_led");

`ifdef WS2812_BRIGHT_EN
        mem0[0] = 24'hFFFFFF;
        mem0[1] = 24'hFFFFFF;
        bright_v = 8'd255;
        run_frame(1'b0, 48'hFFFFFF_FFFFFF, 48, 1'b0, "bright255");
        bright_v = 8'd127;
        run_frame(1'b0, 48'h7F7F7F_7F7F7F, 48, 1'b0, "bright127");
        bright_v = 8'd0;
        run_frame(1'b0, 48'h000000_000000, 48, 1'b0, "bright0");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
